aes_io_bridge: RTL and testbench
================================

// Module: aes_io_bridge
// PURPOSE
//   Hardware-side endpoint of the SoC byte-handshake PIOs (to_hw_port/to_hw_sig in, to_sw_port/to_sw_sig out).
//   Assembles 16 key bytes + 16 message bytes written by software into 128-bit words, pulses start to the
//   AES core, waits for done, then returns the 128-bit result to software one byte per handshake.
//   Sits between the SoC PIO exports and the AES decrypt core in the top level.
// PARAMETERS
//   KEY_BYTES   16  bytes of key received first; key_o width = 8*KEY_BYTES
//   MSG_BYTES   16  bytes of message received next and returned as result; msg_o/result_i width = 8*MSG_BYTES
// PORTS
//   clk          in   1    system clock, same clock as SoC PIOs
//   reset        in   1    synchronous, active-high
//   to_hw_port   in   8    byte from software
//   to_hw_sig    in   2    command: 00 IDLE, 01 WRITE, 10 READ, 11 ABORT
//   to_sw_port   out  8    result byte to software
//   to_sw_sig    out  2    status: 00 WAIT, 01 ACK, 10 BUSY, 11 RESULT_READY
//   key_o        out  128  assembled key, held stable from start_o until next LOAD completes
//   msg_o        out  128  assembled message, same hold rule
//   start_o      out  1    one-cycle pulse to AES core
//   result_i     in   128  AES core output, valid when done_i=1
//   done_i       in   1    one-cycle completion pulse from AES core
// BEHAVIOUR
//   - Reset: state LOAD, byte count 0, to_sw_port=0, to_sw_sig=00, key_o=0, msg_o=0, start_o=0, result reg=0.
//   - to_hw_port/to_hw_sig registered once on entry (sig_q/byte_q); all outputs registered.
//     Response latency: to_sw_sig changes on the 2nd rising edge after to_hw_sig changes.
//   - States: LOAD, LOAD_ACK, START, BUSY, READY, READ_ACK.
//   - LOAD: to_sw_sig=00. sig_q=01 -> capture byte_q at index cnt, cnt++, -> LOAD_ACK.
//     Bytes 0..15 fill key_o MSB-first (byte 0 -> [127:120]); bytes 16..31 fill msg_o likewise.
//     sig_q=10 ignored.
//   - LOAD_ACK: to_sw_sig=01; hold until sig_q=00, then -> START if cnt==32, else -> LOAD.
//     WRITE held high never captures twice.
//   - START: start_o=1 for exactly one cycle, cnt cleared, -> BUSY.
//   - BUSY: to_sw_sig=10; WRITE/READ ignored. done_i=1 -> latch result_i, -> READY.
//   - READY: to_sw_sig=11. sig_q=10 -> to_sw_port=result byte cnt (byte 0 = [127:120]), -> READ_ACK.
//   - READ_ACK: to_sw_sig=01, to_sw_port held; on sig_q=00 cnt++; cnt reaching 16 -> LOAD (cnt=0),
//     else -> READY.
//   - done_i outside BUSY ignored; result reg only written in BUSY.
//   - ABORT (sig_q=11) from any state: -> LOAD, cnt=0, to_sw_sig=00, start_o=0; key_o/msg_o/result
//     retain values. ABORT wins over simultaneous done_i.
//   - Byte counter 6 bits, never exceeds 32; no wrap.
//   - Reset mid-operation behaves exactly as power-on reset on the next edge.
// TESTING
//   1. Reset, write key 00..0F then msg 10..1F via full handshakes -> key_o=0x000102..0F,
//      msg_o=0x101112..1F, one start_o pulse, to_sw_sig=10.
//   2. In BUSY pulse done_i with result_i=0xA0A1..AF -> to_sw_sig=11; 16 READ handshakes return
//      A0,A1,..,AF, then to_sw_sig=00.
//   3. Hold to_hw_sig=01 for 20 cycles on byte 0x55 -> exactly one capture, cnt=1, ACK held until sig=00.
//   4. ABORT after 7 bytes -> to_sw_sig=00 within 2 edges; fresh 32-byte load completes normally.
//   5. done_i while in LOAD, and READ while in BUSY -> no state change, no output change.
//   6. Assert reset during READ_ACK of byte 5 -> all outputs at reset values next edge;
//      ABORT coincident with done_i -> LOAD, result reg unchanged.

Source files
------------

// File: rtl/aes_io_bridge.sv
// Byte-handshake bridge between the SoC PIOs and the AES core: gathers key+message bytes, starts the core, returns the result bytewise.
// Latency: PIO inputs are registered once, so to_sw_sig responds on the 2nd rising edge after to_hw_sig changes.
// Backpressure: four-phase handshake. Software holds a command until it sees ACK, then returns to IDLE before the next byte.
module aes_io_bridge #(
  parameter int KEY_BYTES = 16,
  parameter int MSG_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             to_hw_port,
  input  logic [1:0]             to_hw_sig,
  output logic [7:0]             to_sw_port,
  output logic [1:0]             to_sw_sig,
  output logic [8*KEY_BYTES-1:0] key_o,
  output logic [8*MSG_BYTES-1:0] msg_o,
  output logic                   start_o,
  input  logic [8*MSG_BYTES-1:0] result_i,
  input  logic                   done_i
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int MW = 8 * MSG_BYTES;
  localparam logic [5:0] TOTAL_BYTES = 6'(KEY_BYTES + MSG_BYTES);
  localparam logic [5:0] LAST_RES    = 6'(MSG_BYTES - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [1:0] STS_WAIT  = 2'b00;
  localparam logic [1:0] STS_ACK   = 2'b01;
  localparam logic [1:0] STS_BUSY  = 2'b10;
  localparam logic [1:0] STS_READY = 2'b11;

  typedef enum logic [2:0] {
    S_LOAD, S_LOAD_ACK, S_START, S_BUSY, S_READY, S_READ_ACK
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      sig_q;
  logic [7:0]      byte_q;
  logic [KW-1:0]   key_q, key_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic [MW-1:0]   result_q, result_d;
  logic [7:0]      port_q, port_d;
  logic [1:0]      sts_q, sts_d;
  logic            start_q, start_d;

  // State register plus all registered outputs and the input capture stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      sig_q    <= CMD_IDLE;
      byte_q   <= '0;
      key_q    <= '0;
      msg_q    <= '0;
      result_q <= '0;
      port_q   <= '0;
      sts_q    <= STS_WAIT;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sig_q    <= to_hw_sig;
      byte_q   <= to_hw_port;
      key_q    <= key_d;
      msg_q    <= msg_d;
      result_q <= result_d;
      port_q   <= port_d;
      sts_q    <= sts_d;
      start_q  <= start_d;
    end
  end

  // Next state and datapath: ABORT overrides everything, including a coincident done_i.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    msg_d    = msg_q;
    result_d = result_q;
    port_d   = port_q;
    if (sig_q == CMD_ABORT) begin
      state_d = S_LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (sig_q == CMD_WRITE) begin
            // Byte index cnt lands MSB-first: key bytes first, then message bytes.
            for (int i = 0; i < KEY_BYTES; i++)
              if (cnt_q == 6'(i)) key_d[8*(KEY_BYTES-i)-1 -: 8] = byte_q;
            for (int i = 0; i < MSG_BYTES; i++)
              if (cnt_q == 6'(KEY_BYTES + i)) msg_d[8*(MSG_BYTES-i)-1 -: 8] = byte_q;
            cnt_d   = cnt_q + 6'd1;
            state_d = S_LOAD_ACK;
          end
        end
        S_LOAD_ACK: begin
          if (sig_q == CMD_IDLE)
            state_d = (cnt_q == TOTAL_BYTES) ? S_START : S_LOAD;
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_BUSY;
        end
        S_BUSY: begin
          if (done_i) begin
            result_d = result_i;
            state_d  = S_READY;
          end
        end
        S_READY: begin
          if (sig_q == CMD_READ) begin
            for (int i = 0; i < MSG_BYTES; i++)
              if (cnt_q == 6'(i)) port_d = result_q[8*(MSG_BYTES-i)-1 -: 8];
            state_d = S_READ_ACK;
          end
        end
        S_READ_ACK: begin
          if (sig_q == CMD_IDLE) begin
            if (cnt_q == LAST_RES) begin
              cnt_d   = '0;
              state_d = S_LOAD;
            end else begin
              cnt_d   = cnt_q + 6'd1;
              state_d = S_READY;
            end
          end
        end
        default: begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so status lands on the same edge as the transition.
  always_comb begin
    sts_d   = STS_WAIT;
    start_d = 1'b0;
    case (state_d)
      S_LOAD:     sts_d = STS_WAIT;
      S_LOAD_ACK: sts_d = STS_ACK;
      S_START: begin
        sts_d   = STS_BUSY;
        start_d = 1'b1;
      end
      S_BUSY:     sts_d = STS_BUSY;
      S_READY:    sts_d = STS_READY;
      S_READ_ACK: sts_d = STS_ACK;
      default:    sts_d = STS_WAIT;
    endcase
  end

  assign to_sw_port = port_q;
  assign to_sw_sig  = sts_q;
  assign key_o      = key_q;
  assign msg_o      = msg_q;
  assign start_o    = start_q;

endmodule

// File: tb/tb_aes_io_bridge.sv
// Directed-plus-random bench for aes_io_bridge: software-side handshakes driven from one initial block.
// Expected values come from a byte-array model of what software has written and which result it should read.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_aes_io_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   to_hw_port;
  logic [1:0]   to_hw_sig;
  logic [7:0]   to_sw_port;
  logic [1:0]   to_sw_sig;
  logic [127:0] key_o;
  logic [127:0] msg_o;
  logic         start_o;
  logic [127:0] result_i;
  logic         done_i;

  always #5 clk = ~clk;

  aes_io_bridge #(.KEY_BYTES(16), .MSG_BYTES(16)) dut (
    .clk(clk), .reset(reset),
    .to_hw_port(to_hw_port), .to_hw_sig(to_hw_sig),
    .to_sw_port(to_sw_port), .to_sw_sig(to_sw_sig),
    .key_o(key_o), .msg_o(msg_o), .start_o(start_o),
    .result_i(result_i), .done_i(done_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int exp_starts = 0;

  // Reference model: every byte software has written, how many in the current load, last byte read.
  logic [7:0] kb [32];
  int         wcnt;
  logic [7:0] exp_port;

  always @(posedge clk) if (start_o === 1'b1) start_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  function automatic logic [127:0] pack(input int base);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], kb[base+i]};
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full WRITE handshake, checking latency, ACK, captured data and what follows release.
  task automatic wr(input logic [7:0] b);
    to_hw_sig = 2'b01; to_hw_port = b;
    tick(1); chk("wr_latency", 128'(to_sw_sig), 128'd0);
    tick(1); chk("wr_ack", 128'(to_sw_sig), 128'd1);
    kb[wcnt] = b; wcnt++;
    chk("wr_key", key_o, pack(0));
    chk("wr_msg", msg_o, pack(16));
    to_hw_sig = 2'b00; to_hw_port = 8'($urandom);
    tick(1); chk("wr_ack_hold", 128'(to_sw_sig), 128'd1);
    tick(1);
    if (wcnt == 32) begin
      chk("start_high", 128'(start_o), 128'd1);
      chk("busy_status", 128'(to_sw_sig), 128'd2);
      tick(1); chk("start_low", 128'(start_o), 128'd0);
      wcnt = 0; exp_starts++;
    end else begin
      chk("wr_wait", 128'(to_sw_sig), 128'd0);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 32; i++) wr(8'($urandom));
  endtask

  task automatic pulse_done(input logic [127:0] r);
    done_i = 1'b1; result_i = r;
    tick(1);
    done_i = 1'b0; result_i = rnd128();
  endtask

  task automatic rd(input logic [7:0] e, input bit last);
    to_hw_sig = 2'b10;
    tick(2);
    chk("rd_ack", 128'(to_sw_sig), 128'd1);
    chk("rd_byte", 128'(to_sw_port), 128'(e));
    exp_port = e;
    to_hw_sig = 2'b00;
    tick(2);
    chk("rd_after", 128'(to_sw_sig), last ? 128'd0 : 128'd3);
    chk("rd_port_hold", 128'(to_sw_port), 128'(e));
  endtask

  task automatic read_all(input logic [127:0] r);
    for (int i = 0; i < 16; i++) rd(r[127-8*i -: 8], i == 15);
  endtask

  initial begin
    logic [127:0] r;
    logic [127:0] r1;
    reset = 1'b1; to_hw_port = '0; to_hw_sig = '0; result_i = '0; done_i = 1'b0;
    for (int i = 0; i < 32; i++) kb[i] = 8'h00;
    wcnt = 0; exp_port = 8'h00;
    tick(3);
    chk("rst_sig", 128'(to_sw_sig), 128'd0);
    chk("rst_port", 128'(to_sw_port), 128'd0);
    chk("rst_key", key_o, 128'd0);
    chk("rst_msg", msg_o, 128'd0);
    chk("rst_start", 128'(start_o), 128'd0);
    reset = 1'b0;
    tick(1);

    // Sequential key 00..0F and message 10..1F.
    for (int i = 0; i < 32; i++) wr(8'(i));
    chk("t1_key", key_o, 128'h000102030405060708090a0b0c0d0e0f);
    chk("t1_msg", msg_o, 128'h101112131415161718191a1b1c1d1e1f);

    // Result A0..AF read back over sixteen handshakes.
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'(8'hA0 + i)};
    pulse_done(r);
    chk("t2_ready", 128'(to_sw_sig), 128'd3);
    read_all(r);

    // WRITE held for 20 cycles captures exactly once.
    to_hw_sig = 2'b01; to_hw_port = 8'h55;
    tick(20);
    chk("t3_ack_held", 128'(to_sw_sig), 128'd1);
    kb[0] = 8'h55; wcnt = 1;
    chk("t3_key", key_o, pack(0));
    to_hw_sig = 2'b00;
    tick(2);
    chk("t3_release", 128'(to_sw_sig), 128'd0);
    wr(8'hAA);

    // ABORT from LOAD_ACK after the 7th byte.
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    to_hw_sig = 2'b01; to_hw_port = 8'h77;
    tick(2);
    chk("t4_ack7", 128'(to_sw_sig), 128'd1);
    kb[wcnt] = 8'h77;
    to_hw_sig = 2'b11;
    tick(1); chk("t4_abort_lat", 128'(to_sw_sig), 128'd1);
    tick(1); chk("t4_abort", 128'(to_sw_sig), 128'd0);
    chk("t4_key_kept", key_o, pack(0));
    wcnt = 0;
    to_hw_sig = 2'b00;
    tick(2);

    // done_i in LOAD is ignored.
    pulse_done(rnd128());
    tick(1);
    chk("t5_done_load_sig", 128'(to_sw_sig), 128'd0);
    chk("t5_done_load_port", 128'(to_sw_port), 128'(exp_port));

    load_random();
    // READ and WRITE while BUSY are ignored.
    to_hw_sig = 2'b10;
    tick(4);
    chk("t5_busy_read_sig", 128'(to_sw_sig), 128'd2);
    chk("t5_busy_read_port", 128'(to_sw_port), 128'(exp_port));
    to_hw_sig = 2'b01; to_hw_port = 8'($urandom);
    tick(3);
    chk("t5_busy_write_sig", 128'(to_sw_sig), 128'd2);
    chk("t5_busy_write_key", key_o, pack(0));
    chk("t5_busy_write_msg", msg_o, pack(16));
    to_hw_sig = 2'b00;
    tick(2);

    // Reset in the READ_ACK of byte 5.
    r = rnd128();
    pulse_done(r);
    chk("t6_ready", 128'(to_sw_sig), 128'd3);
    for (int i = 0; i < 5; i++) rd(r[127-8*i -: 8], 1'b0);
    to_hw_sig = 2'b10;
    tick(2);
    chk("t6_ack5", 128'(to_sw_sig), 128'd1);
    chk("t6_byte5", 128'(to_sw_port), 128'(r[127-40 -: 8]));
    reset = 1'b1;
    tick(1);
    chk("t6_rst_sig", 128'(to_sw_sig), 128'd0);
    chk("t6_rst_port", 128'(to_sw_port), 128'd0);
    chk("t6_rst_key", key_o, 128'd0);
    chk("t6_rst_msg", msg_o, 128'd0);
    chk("t6_rst_start", 128'(start_o), 128'd0);
    reset = 1'b0; to_hw_sig = 2'b00;
    for (int i = 0; i < 32; i++) kb[i] = 8'h00;
    wcnt = 0; exp_port = 8'h00;
    tick(2);

    // Normal cycle after reset, then ABORT coincident with done_i.
    load_random();
    r1 = rnd128();
    pulse_done(r1);
    read_all(r1);
    load_random();
    to_hw_sig = 2'b11;
    tick(1);
    done_i = 1'b1; result_i = rnd128();
    tick(1);
    done_i = 1'b0;
    chk("t6_abort_done_sig", 128'(to_sw_sig), 128'd0);
    to_hw_sig = 2'b00;
    tick(2);
    to_hw_sig = 2'b10;
    tick(3);
    chk("t6_no_ready_sig", 128'(to_sw_sig), 128'd0);
    chk("t6_no_ready_port", 128'(to_sw_port), 128'(exp_port));
    to_hw_sig = 2'b00;
    tick(2);

    // A further random transaction proves the bridge is healthy afterwards.
    load_random();
    r = rnd128();
    pulse_done(r);
    read_all(r);

    tick(2);
    chk("start_pulses", 128'(start_cnt), 128'(exp_starts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
